// File: rtl/sync_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_pkg : shared defaults and width helper for sync_filter_edge      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package sync_pkg;

    localparam int DEF_NUM_STAGES = 2;
    localparam int DEF_FILT_LEN   = 3;
    localparam int DEF_NUM_CH     = 4;

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_filter_edge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_filter_edge_if : async input bus and filtered level/edge outputs |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface sync_filter_edge_if
    import sync_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
);

    logic [NUM_CH-1:0] ASYNC;
    logic [NUM_CH-1:0] SYNC;
    logic [NUM_CH-1:0] RISE;
    logic [NUM_CH-1:0] FALL;

    modport master (output ASYNC, input SYNC, input RISE, input FALL);
    modport slave  (input ASYNC, output SYNC, output RISE, output FALL);

endinterface
`default_nettype wire

// File: rtl/sync_filter_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_filter_ch : single-channel stability filter with edge pulses     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int   FILT_LEN = DEF_FILT_LEN,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_s,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    localparam int              CNT_W     = clog2_min1(FILT_LEN);
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(FILT_LEN - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sync;
    logic             r_rise;
    logic             r_fall;

    // Any return of i_s to the held level wipes the count: no partial credit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt  <= '0;
            r_sync <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_s == r_sync) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                r_cnt  <= '0;
                r_sync <= i_s;
                r_rise <= i_s;
                r_fall <= ~i_s;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/sync_filter_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_filter_edge : multi-channel synchroniser, glitch filter, edges   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_filter_edge
    import sync_pkg::*;
#(
    parameter int              NUM_STAGES = DEF_NUM_STAGES,
    parameter int              NUM_CH     = DEF_NUM_CH,
    parameter int              FILT_LEN   = DEF_FILT_LEN,
    parameter logic [NUM_CH-1:0] RST_VAL  = {NUM_CH{1'b0}}
) (
    input  logic              CLK,
    input  logic              RST,
    sync_filter_edge_if.slave bus
);

    if (NUM_STAGES < 1) begin : g_bad_stages
        $error("sync_filter_edge: NUM_STAGES must be >= 1");
    end
    if (FILT_LEN < 1) begin : g_bad_filt
        $error("sync_filter_edge: FILT_LEN must be >= 1");
    end

    logic [NUM_CH-1:0] r_stage [NUM_STAGES];
    logic [NUM_CH-1:0] w_s;
    logic [NUM_CH-1:0] w_sync;
    logic [NUM_CH-1:0] w_rise;
    logic [NUM_CH-1:0] w_fall;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_stage[k] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= bus.ASYNC;
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign w_s = r_stage[NUM_STAGES-1];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_filter_ch #(
            .FILT_LEN (FILT_LEN),
            .RST_VAL  (RST_VAL[i])
        ) u_ch (
            .CLK    (CLK),
            .RST    (RST),
            .i_s    (w_s[i]),
            .o_sync (w_sync[i]),
            .o_rise (w_rise[i]),
            .o_fall (w_fall[i])
        );
    end

    assign bus.SYNC = w_sync;
    assign bus.RISE = w_rise;
    assign bus.FALL = w_fall;

endmodule
`default_nettype wire

// File: tb/tb_sync_filter_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_filter_edge : three parameterisations against a window model  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_sync_filter_edge;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic [3:0] async_v [3];

    int n_chk  = 0;
    int n_fail = 0;

    // Per-DUT configuration: a = defaults, b = RST_VAL 4'hF, c = 1 stage/1 filt/1 ch
    int         ns   [3] = '{2, 2, 1};
    int         fl   [3] = '{3, 3, 1};
    logic [3:0] rv   [3] = '{4'h0, 4'hF, 4'h0};
    logic [3:0] mask [3] = '{4'hF, 4'hF, 4'h1};

    sync_filter_edge_if #(.NUM_CH(4)) if_a ();
    sync_filter_edge_if #(.NUM_CH(4)) if_b ();
    sync_filter_edge_if #(.NUM_CH(1)) if_c ();

    sync_filter_edge #(.NUM_STAGES(2), .NUM_CH(4), .FILT_LEN(3), .RST_VAL(4'h0))
        dut_a (.CLK(CLK), .RST(RST), .bus(if_a.slave));
    sync_filter_edge #(.NUM_STAGES(2), .NUM_CH(4), .FILT_LEN(3), .RST_VAL(4'hF))
        dut_b (.CLK(CLK), .RST(RST), .bus(if_b.slave));
    sync_filter_edge #(.NUM_STAGES(1), .NUM_CH(1), .FILT_LEN(1), .RST_VAL(1'b0))
        dut_c (.CLK(CLK), .RST(RST), .bus(if_c.slave));

    assign if_a.ASYNC = async_v[0];
    assign if_b.ASYNC = async_v[1];
    assign if_c.ASYNC = async_v[2][0];

    logic [3:0] d_sync [3];
    logic [3:0] d_rise [3];
    logic [3:0] d_fall [3];
    assign d_sync[0] = if_a.SYNC;
    assign d_rise[0] = if_a.RISE;
    assign d_fall[0] = if_a.FALL;
    assign d_sync[1] = if_b.SYNC;
    assign d_rise[1] = if_b.RISE;
    assign d_fall[1] = if_b.FALL;
    assign d_sync[2] = {3'b000, if_c.SYNC};
    assign d_rise[2] = {3'b000, if_c.RISE};
    assign d_fall[2] = {3'b000, if_c.FALL};

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: s is ASYNC delayed by NUM_STAGES samples; SYNC flips when the
    // last FILT_LEN samples of s all disagree with it.
    logic [3:0] a_hist [3][16];
    logic [3:0] s_hist [3][16];
    logic [3:0] m_sync [3];
    logic [3:0] m_rise [3];
    logic [3:0] m_fall [3];

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 16; k++) begin
                a_hist[d][k] = rv[d];
                s_hist[d][k] = rv[d];
            end
            m_sync[d] = rv[d];
            m_rise[d] = 4'h0;
            m_fall[d] = 4'h0;
        end
    endtask

    task automatic model_step();
        logic [3:0] s_now;
        bit         all_diff;
        for (int d = 0; d < 3; d++) begin
            s_now = a_hist[d][ns[d]-1];
            for (int k = 15; k > 0; k--) begin
                a_hist[d][k] = a_hist[d][k-1];
                s_hist[d][k] = s_hist[d][k-1];
            end
            a_hist[d][0] = async_v[d] & mask[d];
            s_hist[d][0] = s_now;
            m_rise[d] = 4'h0;
            m_fall[d] = 4'h0;
            for (int i = 0; i < 4; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < fl[d]; j++) begin
                    if (s_hist[d][j][i] == m_sync[d][i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_sync[d][i] = s_now[i];
                    m_rise[d][i] = s_now[i];
                    m_fall[d][i] = ~s_now[i];
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) model_reset();
            else      model_step();
        end
    end

    int rc [3][4];
    int fc [3][4];

    initial begin
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 4; i++) begin
                rc[d][i] = 0;
                fc[d][i] = 0;
            end
        forever begin
            @(negedge CLK);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("sync_d%0d", d), d_sync[d], m_sync[d]);
                chk($sformatf("rise_d%0d", d), d_rise[d], m_rise[d]);
                chk($sformatf("fall_d%0d", d), d_fall[d], m_fall[d]);
                for (int i = 0; i < 4; i++) begin
                    rc[d][i] += int'(d_rise[d][i]);
                    fc[d][i] += int'(d_fall[d][i]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 required");
        $fatal(1, "watchdog");
    end

    task automatic adv();
        @(posedge CLK);
        #1;
    endtask

    int b_r, b_f;

    initial begin
        async_v[0] = 4'h0;
        async_v[1] = 4'hF;
        async_v[2] = 4'h0;
        repeat (3) adv();
        chk("rst_sync_a", if_a.SYNC, 4'h0);
        chk("rst_sync_b", if_b.SYNC, 4'hF);
        chk("rst_pulse_a", if_a.RISE | if_a.FALL, 4'h0);
        chk("rst_pulse_b", if_b.RISE | if_b.FALL, 4'h0);
        RST = 1'b1;
        repeat (3) adv();

        // Latency: edge set up before edge 1 appears at edge 5
        async_v[0] = 4'b0001;
        for (int e = 1; e <= 6; e++) begin
            adv();
            if (e == 4) begin
                chk("lat_e4_sync", if_a.SYNC, 4'b0000);
                chk("lat_e4_rise", if_a.RISE, 4'b0000);
            end
            if (e == 5) begin
                chk("lat_e5_sync", if_a.SYNC, 4'b0001);
                chk("lat_e5_rise", if_a.RISE, 4'b0001);
                chk("lat_e5_fall", if_a.FALL, 4'b0000);
            end
            if (e == 6) chk("lat_e6_rise", if_a.RISE, 4'b0000);
        end

        // Glitch of 2 cycles is ignored, 3 cycles passes
        b_r = rc[0][1];
        b_f = fc[0][1];
        async_v[0][1] = 1'b1;
        repeat (2) adv();
        async_v[0][1] = 1'b0;
        repeat (8) adv();
        chk("glitch2_rise", 4'(rc[0][1] - b_r), 4'd0);
        chk("glitch2_sync", if_a.SYNC, 4'b0001);
        async_v[0][1] = 1'b1;
        repeat (3) adv();
        async_v[0][1] = 1'b0;
        repeat (8) adv();
        chk("glitch3_rise", 4'(rc[0][1] - b_r), 4'd1);
        chk("glitch3_fall", 4'(fc[0][1] - b_f), 4'd1);

        // Simultaneous channel changes
        async_v[0] = 4'b0000;
        repeat (8) adv();
        async_v[0] = 4'b1010;
        for (int e = 1; e <= 6; e++) begin
            adv();
            if (e == 5) begin
                chk("sim1_rise", if_a.RISE, 4'b1010);
                chk("sim1_sync", if_a.SYNC, 4'b1010);
            end
            if (e == 6) chk("sim1_rise_e6", if_a.RISE, 4'b0000);
        end
        async_v[0] = 4'b0101;
        for (int e = 1; e <= 5; e++) begin
            adv();
            if (e == 5) begin
                chk("sim2_rise", if_a.RISE, 4'b0101);
                chk("sim2_fall", if_a.FALL, 4'b1010);
                chk("sim2_sync", if_a.SYNC, 4'b0101);
            end
        end

        // Asynchronous reset mid-count
        async_v[0] = 4'b0001;
        repeat (8) adv();
        chk("pre_rst_sync", if_a.SYNC, 4'b0001);
        async_v[0] = 4'b0101;
        repeat (3) adv();
        #1;
        RST = 1'b0;
        #1;
        chk("rst_async_sync", if_a.SYNC, 4'b0000);
        chk("rst_async_pulse", if_a.RISE | if_a.FALL, 4'b0000);
        repeat (2) adv();
        RST = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            adv();
            if (e == 4) chk("rel_e4_sync", if_a.SYNC, 4'b0000);
            if (e == 5) begin
                chk("rel_e5_rise", if_a.RISE, 4'b0101);
                chk("rel_e5_sync", if_a.SYNC, 4'b0101);
            end
        end

        // RST_VAL all ones: no pulses from reset, then a single FALL
        repeat (20) adv();
        chk("b_no_pulse", 4'(rc[1][0] + rc[1][1] + rc[1][2] + rc[1][3]
                             + fc[1][0] + fc[1][1] + fc[1][2] + fc[1][3]), 4'd0);
        async_v[1] = 4'b0111;
        repeat (8) adv();
        chk("b_fall3", 4'(fc[1][3]), 4'd1);
        chk("b_fall_total", 4'(fc[1][0] + fc[1][1] + fc[1][2] + fc[1][3]), 4'd1);
        chk("b_rise_total", 4'(rc[1][0] + rc[1][1] + rc[1][2] + rc[1][3]), 4'd0);
        chk("b_sync", if_b.SYNC, 4'b0111);

        // Minimal configuration: follows at edge 2, alternating input
        async_v[2] = 4'h1;
        for (int e = 1; e <= 3; e++) begin
            adv();
            if (e == 1) chk("c_e1_sync", d_sync[2], 4'h0);
            if (e == 2) begin
                chk("c_e2_sync", d_sync[2], 4'h1);
                chk("c_e2_rise", d_rise[2], 4'h1);
            end
            if (e == 3) chk("c_e3_rise", d_rise[2], 4'h0);
        end
        b_r = rc[2][0];
        b_f = fc[2][0];
        for (int k = 0; k < 16; k++) begin
            async_v[2][0] = ~async_v[2][0];
            adv();
        end
        repeat (4) adv();
        chk("c_alt_rise", 4'(rc[2][0] - b_r), 4'd8);
        chk("c_alt_fall", 4'(fc[2][0] - b_f), 4'd8);

        // Randomised slow-changing inputs with one mid-cycle reset
        for (int n = 0; n < 400; n++) begin
            adv();
            for (int d = 0; d < 3; d++) begin
                if ($urandom_range(2) == 0)
                    async_v[d][$urandom_range(3)] ^= 1'b1;
            end
            if (n == 150) begin
                #2;
                RST = 1'b0;
            end
            if (n == 153) RST = 1'b1;
        end
        repeat (5) adv();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_filter_edge.md
Name: sync_filter_edge

Overview:
- Multi-channel successor to the single-level bit synchroniser: each channel of an asynchronous input bus passes through a parametrised flop chain, then a per-channel stability (glitch) filter.
- Registered RISE/FALL one-cycle pulses are produced per channel.
- Sits at the system boundary on slow asynchronous control lines (UART RX idle detect, external enables, buttons) feeding the system-clock domain.

Parameters:
- NUM_STAGES, 2, synchroniser flop depth per channel; legal range >= 1.
- NUM_CH, 4, number of independent channels.
- FILT_LEN, 3, consecutive cycles a synchronised value must differ from SYNC before SYNC follows it; legal range >= 1 (1 = no filtering).
- RST_VAL, {NUM_CH{1'b0}}, per-channel reset level of the chain, SYNC and the idle comparison.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  asynchronous active-low reset.
- ASYNC  input  NUM_CH  asynchronous inputs, one bit per channel.
- SYNC  output  NUM_CH  synchronised, filtered level per channel (registered).
- RISE  output  NUM_CH  one-cycle pulse, asserted in the cycle SYNC[i] goes 0->1.
- FALL  output  NUM_CH  one-cycle pulse, asserted in the cycle SYNC[i] goes 1->0.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-low.
- Reset (RST=0):
  - All chain stages = RST_VAL.
  - SYNC = RST_VAL.
  - All filter counters = 0.
  - RISE = FALL = 0.
  - Takes effect immediately, independent of CLK, including mid-count.
- Release: no RISE/FALL pulses are generated from the reset state itself, even when RST_VAL=1.
- Chain:
  - stage[0] <= ASYNC; stage[k] <= stage[k-1].
  - s = stage[NUM_STAGES-1]. All channels share stage registers bit-wise and are fully independent.
- Filter, per channel i, with counter cnt[i] of width $clog2(FILT_LEN) (min 1):
  - s[i]==SYNC[i]: cnt[i] <= 0. SYNC holds. No pulse.
  - s[i]!=SYNC[i] and cnt[i]==FILT_LEN-1: SYNC[i] <= s[i]; cnt[i] <= 0; RISE[i] <= s[i]; FALL[i] <= ~s[i].
  - s[i]!=SYNC[i] otherwise: cnt[i] <= cnt[i]+1. No pulse.
- Pulses: RISE/FALL default to 0 each cycle. They are never high for two consecutive cycles, and RISE[i] and FALL[i] are never high together.
- Glitch rejection:
  - Any excursion of s[i] shorter than FILT_LEN cycles is ignored.
  - The counter clears on the first cycle s[i] returns to SYNC[i]; there is no partial credit carried between excursions.
- Latency: an ASYNC edge meeting setup before CLK edge 1 and held stable appears on SYNC, with its pulse, at edge NUM_STAGES+FILT_LEN.
  - Default: edge 5.
  - FILT_LEN=1: edge NUM_STAGES+1.
- Simultaneous events: multiple channels changing in the same cycle are handled independently. Each produces its own pulse in its own latency-determined cycle.
- Counter never exceeds FILT_LEN-1, so no wrap-around is possible.
- Elaboration: NUM_STAGES<1 or FILT_LEN<1 produces an elaboration error via generate-time check.

Decomposition:
- Shared package (sync_pkg): default NUM_STAGES and FILT_LEN constants, plus a clog2-min-1 width helper function.
- One sub-module, sync_filter_ch: single-channel filter (counter, SYNC bit, RISE/FALL flops).
  - Instantiated NUM_CH times in a generate loop.
  - The chain stays in the top as a NUM_STAGES x NUM_CH register array.

Test Plan:
- Latency, defaults: ASYNC[0] 0->1 before edge 1, held -> SYNC[0]=1 and RISE[0]=1 at edge 5 only; RISE[0]=0 at edge 6; other channels unchanged.
- Glitch: ASYNC[1] high for exactly 2 cycles (FILT_LEN=3) -> SYNC[1] stays 0, no RISE/FALL. Then high for 3 cycles -> RISE[1] pulses once; low again -> FALL[1] pulses FILT_LEN cycles after s falls.
- Simultaneous: ASYNC 4'b0000->4'b1010 in one cycle -> RISE=4'b1010 for one cycle at edge 5, SYNC=4'b1010. Then 4'b1010->4'b0101 -> RISE=4'b0101 and FALL=4'b1010 in the same cycle.
- Reset mid-count: ASYNC[2] rises, assert RST at edge 4 (cnt[2]=1) -> SYNC=0, RISE=FALL=0, cnt cleared asynchronously. After release with ASYNC[2] still 1 -> RISE[2] at release edge+NUM_STAGES+FILT_LEN.
- RST_VAL=4'hF, ASYNC held 4'hF through reset release -> no pulses for 20 cycles. Then ASYNC[3]->0 -> FALL[3] only.
- Parameter sweep NUM_STAGES=1, FILT_LEN=1, NUM_CH=1: single edge -> SYNC follows at edge 2 with one-cycle pulse. Alternating ASYNC every cycle -> SYNC tracks with 2-cycle delay, pulses every cycle, never RISE and FALL together.
